// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, slot packing helpers and FSM states for the matrix units.
package matrix_pkg;
   localparam int MAX_DIM = 5;
   localparam int ELEM_W = 8;
   localparam int MAT_W = MAX_DIM * MAX_DIM * ELEM_W;
   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
   function automatic logic [7:0] slot_off(input logic [2:0] r, input logic [2:0] c);
      return 8'((32'(r) * MAX_DIM + 32'(c)) * ELEM_W);
   endfunction
   function automatic logic dims_ok(input logic [2:0] m, input logic [2:0] n);
      return m != 3'd0 && m <= 3'(MAX_DIM) && n != 3'd0 && n <= 3'(MAX_DIM);
   endfunction
endpackage

// File: rtl/matrix_stream_loader_if.sv
// matrix_stream_loader_if: shape request, element stream and packed matrix result.
interface matrix_stream_loader_if;
   import matrix_pkg::*;
   logic start;
   logic [2:0] dim_m;
   logic [2:0] dim_n;
   logic in_valid;
   logic [ELEM_W-1:0] in_data;
   logic in_ready;
   logic [MAT_W-1:0] matrix_out;
   logic [2:0] out_m;
   logic [2:0] out_n;
   logic busy;
   logic done;
   logic err;
   modport master (
      output start, dim_m, dim_n, in_valid, in_data,
      input in_ready, matrix_out, out_m, out_n, busy, done, err
   );
   modport slave (
      input start, dim_m, dim_n, in_valid, in_data,
      output in_ready, matrix_out, out_m, out_n, busy, done, err
   );
endinterface

// File: rtl/matrix_index_counter.sv
// matrix_index_counter: row-major row/col walker with a flag on the last element of the shape.
module matrix_index_counter (
   input logic clk,
   input logic reset,
   input logic clr,
   input logic en,
   input logic [2:0] dim_m,
   input logic [2:0] dim_n,
   output logic [2:0] row,
   output logic [2:0] col,
   output logic last
);
   logic wrap;
   assign wrap = col == dim_n - 3'd1;
   assign last = wrap && row == dim_m - 3'd1;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         row <= 3'd0;
         col <= 3'd0;
      end else if (clr) begin
         row <= 3'd0;
         col <= 3'd0;
      end else if (en) begin
         col <= wrap ? 3'd0 : col + 3'd1;
         row <= wrap ? row + 3'd1 : row;
      end
endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: collects a serial element stream into the packed 5x5 matrix word.
module matrix_stream_loader
   import matrix_pkg::*;
(
   input logic clk,
   input logic reset,
   matrix_stream_loader_if.slave bus
);
   state_t state;
   logic [2:0] row, col;
   logic last, go, ok, beat;
   assign go = (state == IDLE || state == ERR) && bus.start;
   assign ok = dims_ok(bus.dim_m, bus.dim_n);
   assign beat = state == LOAD && bus.in_valid && bus.in_ready;
   matrix_index_counter u_idx (
      .clk(clk),
      .reset(reset),
      .clr(go && ok),
      .en(beat),
      .dim_m(bus.out_m),
      .dim_n(bus.out_n),
      .row(row),
      .col(col),
      .last(last)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         bus.matrix_out <= '0;
         bus.out_m <= 3'd0;
         bus.out_n <= 3'd0;
         bus.in_ready <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.err <= 1'b0;
      end else begin
         case (state)
            IDLE, ERR:
               if (go && ok) begin
                  state <= LOAD;
                  bus.matrix_out <= '0;
                  bus.out_m <= bus.dim_m;
                  bus.out_n <= bus.dim_n;
                  bus.err <= 1'b0;
                  bus.in_ready <= 1'b1;
                  bus.busy <= 1'b1;
               end else if (go) begin
                  state <= ERR;
                  bus.err <= 1'b1;
               end
            LOAD:
               if (beat) begin
                  bus.matrix_out[slot_off(row, col) +: ELEM_W] <= bus.in_data;
                  if (last) begin
                     state <= DONE;
                     bus.in_ready <= 1'b0;
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                  end
               end
            DONE: begin
               state <= IDLE;
               bus.done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader: directed plan plus randomized loads against a slot-array model.
module tb_matrix_stream_loader;
   import matrix_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   logic [7:0] q[$];
   logic [MAT_W-1:0] exp_mat = '0;
   logic [2:0] exp_m = 3'd0;
   logic [2:0] exp_n = 3'd0;
   matrix_stream_loader_if bus ();
   matrix_stream_loader dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
   task automatic check(input string tag, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic model_fill(input int m, input int n);
      exp_mat = '0;
      for (int r = 0; r < m; r++)
         for (int c = 0; c < n; c++)
            exp_mat[(r * MAX_DIM + c) * ELEM_W +: ELEM_W] = q[r * n + c];
      exp_m = 3'(m);
      exp_n = 3'(n);
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_mat"}, bus.matrix_out, '0);
      check({tag, "_om"}, bus.out_m, 0);
      check({tag, "_on"}, bus.out_n, 0);
      check({tag, "_rdy"}, bus.in_ready, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_err"}, bus.err, 0);
   endtask
   task automatic bad_start(input int m, input int n);
      @(negedge clk);
      bus.start = 1'b1;
      bus.dim_m = 3'(m);
      bus.dim_n = 3'(n);
      @(negedge clk);
      bus.start = 1'b0;
      check("bad_err", bus.err, 1);
      check("bad_rdy", bus.in_ready, 0);
      check("bad_busy", bus.busy, 0);
      check("bad_mat", bus.matrix_out, exp_mat);
      check("bad_om", bus.out_m, exp_m);
      check("bad_on", bus.out_n, exp_n);
      @(negedge clk);
      check("bad_hold", bus.err, 1);
   endtask
   // mode 0: back-to-back, 1: valid pattern 1,0,0 repeating, 2: random valid
   task automatic load(input int m, input int n, input int mode, input int abort, input bit midstart);
      int idx = 0;
      int k = 0;
      logic v, acc;
      @(negedge clk);
      bus.start = 1'b1;
      bus.dim_m = 3'(m);
      bus.dim_n = 3'(n);
      @(negedge clk);
      bus.start = 1'b0;
      check("ld_busy", bus.busy, 1);
      check("ld_rdy", bus.in_ready, 1);
      check("ld_err", bus.err, 0);
      check("ld_clear", bus.matrix_out, '0);
      while (idx < m * n && k < 2000) begin
         if (idx == abort) begin
            bus.in_valid = 1'b0;
            #2 reset = 1'b0;
            #1 check_zero("rst_mid");
            @(negedge clk);
            reset = 1'b1;
            exp_mat = '0;
            exp_m = 3'd0;
            exp_n = 3'd0;
            return;
         end
         v = mode == 0 ? 1'b1 : mode == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
         bus.start = midstart && idx == 2;
         if (bus.start) begin
            bus.dim_m = 3'd4;
            bus.dim_n = 3'd4;
         end
         bus.in_valid = v;
         bus.in_data = q[idx];
         acc = v && bus.in_ready;
         @(negedge clk);
         k++;
         if (acc) idx++;
         if (idx < m * n) check("early_done", bus.done, 0);
      end
      bus.in_valid = 1'b0;
      bus.start = 1'b0;
      if (k >= 2000) check("load_timeout", 1, 0);
      model_fill(m, n);
      check("done", bus.done, 1);
      check("mat", bus.matrix_out, exp_mat);
      check("om", bus.out_m, exp_m);
      check("on", bus.out_n, exp_n);
      check("rdy_drop", bus.in_ready, 0);
      check("busy_drop", bus.busy, 0);
      @(negedge clk);
      check("done_pulse", bus.done, 0);
      check("mat_hold", bus.matrix_out, exp_mat);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.dim_m = 3'd0;
      bus.dim_n = 3'd0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'd0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;
      q = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd5};
      load(2, 3, 0, -1, 0);
      check("b40", bus.matrix_out[47:40], 3);
      q = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd3, 8'd2};
      load(3, 2, 1, -1, 0);
      check("b88", bus.matrix_out[95:88], 2);
      bad_start(0, 3);
      bad_start(6, 2);
      q = '{8'd9};
      load(1, 1, 0, -1, 0);
      check("b0", bus.matrix_out[7:0], 9);
      q.delete();
      for (int i = 1; i <= 25; i++) q.push_back(8'(i));
      load(5, 5, 0, -1, 0);
      check("b192", bus.matrix_out[199:192], 25);
      q = '{8'd7, 8'd8};
      load(1, 2, 0, -1, 0);
      q = '{8'd11, 8'd12, 8'd13, 8'd14};
      load(2, 2, 0, -1, 1);
      q = '{8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26};
      load(2, 3, 0, 3, 0);
      check_zero("after_rst");
      load(2, 3, 0, -1, 0);
      repeat (12) begin
         int m, n;
         if ($urandom_range(0, 3) == 0)
            bad_start($urandom_range(0, 1) ? 0 : $urandom_range(6, 7), $urandom_range(0, 7));
         m = $urandom_range(1, 5);
         n = $urandom_range(1, 5);
         q.delete();
         for (int i = 0; i < m * n; i++) q.push_back(8'($urandom));
         load(m, n, 2, -1, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
